// File: rtl/alu_legv8_pkg.sv
// rtl/alu_legv8_pkg.sv - shared opcode, operand-invert and status-bit definitions for alu_legv8
package alu_legv8_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;

    localparam int FS_INV_A = 1;
    localparam int FS_INV_B = 0;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    // Signed overflow: like-signed operands producing a result of the other sign.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_legv8.sv
// rtl/adder_legv8.sv - WIDTH-bit Kogge-Stone prefix adder with carry-in and carry-out
module adder_legv8 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] gen_w;
    logic [WIDTH-1:0] prop_w;
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;
    logic [WIDTH-1:0] carry;

    assign gen_w  = a_i & b_i;
    assign prop_w = a_i ^ b_i;

    // Walking each level from the top down lets the in-place update still see
    // the previous level's values at the lower indices it combines with.
    always_comb begin
        grp_g = gen_w;
        grp_p = prop_w;
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << k)]);
                grp_p[i] = grp_p[i] & grp_p[i - (1 << k)];
            end
        end
    end

    assign carry  = {grp_g[WIDTH-2:0] | (grp_p[WIDTH-2:0] & {(WIDTH-1){cin_i}}), cin_i};
    assign sum_o  = prop_w ^ carry;
    assign cout_o = grp_g[WIDTH-1] | (grp_p[WIDTH-1] & cin_i);

endmodule

// File: rtl/alu_legv8.sv
// rtl/alu_legv8.sv - LEGv8 execute-stage ALU: logic ops, add, shifts, registered result and {V,C,N,Z}
module alu_legv8
    import alu_legv8_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    input  logic             C0,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       status
);

    localparam int SHW = $clog2(WIDTH);

    logic [2:0]       op;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] f_q;
    logic [3:0]       status_d;
    logic [3:0]       status_q;

    assign op    = FS[4:2];
    assign a2    = FS[FS_INV_A] ? ~A : A;
    assign b2    = FS[FS_INV_B] ? ~B : B;
    assign shamt = B[SHW-1:0];

    adder_legv8 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (a2),
        .b_i    (b2),
        .cin_i  (C0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Shifts use the raw A operand; the invert bits only steer the logic/add path.
    always_comb begin
        r_d = '0;
        case (op)
            OP_AND:  r_d = a2 & b2;
            OP_OR:   r_d = a2 | b2;
            OP_ADD:  r_d = sum;
            OP_XOR:  r_d = a2 ^ b2;
            OP_LSL:  r_d = A << shamt;
            OP_LSR:  r_d = A >> shamt;
            default: r_d = '0;
        endcase
    end

    always_comb begin
        status_d       = '0;
        status_d[ST_Z] = (r_d == '0);
        status_d[ST_N] = r_d[WIDTH-1];
        if (op == OP_ADD) begin
            status_d[ST_C] = cout;
            status_d[ST_V] = add_overflow(a2[WIDTH-1], b2[WIDTH-1], r_d[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q      <= '0;
            status_q <= '0;
        end else begin
            f_q      <= r_d;
            status_q <= status_d;
        end
    end

    assign F      = f_q;
    assign status = status_q;

endmodule

// File: tb/tb_alu_legv8.sv
// tb/tb_alu_legv8.sv - scoreboard bench for alu_legv8: directed vectors, random vectors, async reset
module tb_alu_legv8;

    logic        clk;
    logic        rst_n;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  FS;
    logic        C0;
    logic [63:0] F;
    logic [3:0]  status;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_f_q[$];
    logic [3:0]  exp_s_q[$];
    string       tag_q[$];

    alu_legv8 #(.WIDTH(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .FS     (FS),
        .C0     (C0),
        .F      (F),
        .status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compare_pending();
        logic [63:0] ef;
        logic [3:0]  es;
        string       t;
        if (exp_f_q.size() > 0) begin
            ef = exp_f_q.pop_front();
            es = exp_s_q.pop_front();
            t  = tag_q.pop_front();
            check({t, "_F"}, F, ef);
            check({t, "_status"}, {60'd0, status}, {60'd0, es});
        end
    endtask

    task automatic push_exp(input logic [63:0] ef, input logic [3:0] es, input string t);
        exp_f_q.push_back(ef);
        exp_s_q.push_back(es);
        tag_q.push_back(t);
    endtask

    task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs,
                         input logic c0, input logic [63:0] ef, input logic [3:0] es, input string t);
        @(negedge clk);
        compare_pending();
        A  = a;
        B  = b;
        FS = fs;
        C0 = c0;
        push_exp(ef, es, t);
    endtask

    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] fs, input logic c0);
        logic [63:0] a2, b2, r;
        logic [64:0] s;
        logic        v, c;
        a2 = fs[1] ? ~a : a;
        b2 = fs[0] ? ~b : b;
        v  = 1'b0;
        c  = 1'b0;
        case (fs[4:2])
            3'd0: r = a2 & b2;
            3'd1: r = a2 | b2;
            3'd2: begin
                s = {1'b0, a2} + {1'b0, b2} + {64'd0, c0};
                r = s[63:0];
                c = s[64];
                v = (a2[63] == b2[63]) && (r[63] != a2[63]);
            end
            3'd3: r = a2 ^ b2;
            3'd4: r = a << b[5:0];
            3'd5: r = a >> b[5:0];
            default: r = 64'd0;
        endcase
        return {v, c, r[63], (r == 64'd0), r};
    endfunction

    initial begin
        logic [63:0] ra, rb;
        logic [4:0]  rfs;
        logic        rc0;
        logic [67:0] m;

        rst_n = 1'b0;
        A     = 64'd6;
        B     = 64'd3;
        FS    = 5'b00100;
        C0    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_F", F, 64'd0);
        check("rst_status", {60'd0, status}, 64'd0);

        rst_n = 1'b1;
        push_exp(64'd7, 4'b0000, "first");

        apply(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 5'b00000, 1'b0, 64'd0, 4'b0001, "and_z");
        apply(64'd6, 64'd3, 5'b00100, 1'b0, 64'd7, 4'b0000, "or");
        apply(64'd6, 64'd3, 5'b01000, 1'b0, 64'd9, 4'b0000, "add");
        apply(64'd6, 64'd3, 5'b01001, 1'b1, 64'd3, 4'b0100, "sub");
        apply(64'd6, 64'd3, 5'b01100, 1'b0, 64'd5, 4'b0000, "xor");
        apply(64'd2345, 64'd4, 5'b00011, 1'b0, 64'hFFFF_FFFF_FFFF_F6D2, 4'b0010, "nor");
        apply(64'd2345, 64'd4, 5'b00111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, "nand");
        apply(64'd1, 64'd4, 5'b10000, 1'b0, 64'h10, 4'b0000, "lsl");
        apply(64'h8000_0000_0000_0000, 64'd4, 5'b10100, 1'b0, 64'h0800_0000_0000_0000, 4'b0000, "lsr");
        apply(64'h1234, 64'h40, 5'b10011, 1'b1, 64'h1234, 4'b0000, "lsl_wrap0");
        apply(64'h1234, 64'h40, 5'b10100, 1'b0, 64'h1234, 4'b0000, "lsr_wrap0");
        apply(64'd1, 64'd63, 5'b10000, 1'b0, 64'h8000_0000_0000_0000, 4'b0010, "lsl63");
        apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, "add_ovf");
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'd0, 4'b0101, "add_wrap");
        apply(64'd5, 64'd5, 5'b11000, 1'b0, 64'd0, 4'b0001, "op110");
        apply(64'd5, 64'd5, 5'b11111, 1'b1, 64'd0, 4'b0001, "op111");

        for (int i = 0; i < 40; i++) begin
            ra  = {$urandom, $urandom};
            rb  = (i % 4 == 0) ? ra : {$urandom, $urandom};
            rfs = 5'($urandom_range(0, 31));
            rc0 = 1'($urandom_range(0, 1));
            m   = model(ra, rb, rfs, rc0);
            apply(ra, rb, rfs, rc0, m[63:0], m[67:64], "rand");
        end

        // Load a result with nonzero F and status, then pull reset between edges.
        apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, "pre_rst");
        @(negedge clk);
        compare_pending();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_F", F, 64'd0);
        check("async_status", {60'd0, status}, 64'd0);
        @(negedge clk);
        A  = 64'd1;
        B  = 64'd4;
        FS = 5'b10000;
        @(posedge clk);
        #1;
        check("hold_F", F, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(64'h10, 4'b0000, "release");
        @(negedge clk);
        compare_pending();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
